// File: rtl/rx_bit_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_bit_timer_pkg
// Description : Shared types and default timing constants for the USB
//               full-speed receive bit timer.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_bit_timer_pkg;

  // Controller states: IDLE holds everything cleared, ARM waits for the
  // first data edge, RUN performs bit timing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } timer_state_t;

  localparam int DEF_CLKS_PER_BIT  = 8;
  localparam int DEF_SAMPLE_PHASE  = 3;
  localparam int DEF_BITS_PER_BYTE = 8;

endpackage
`default_nettype wire

// File: rtl/rx_bit_timer_flex.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter
// Description : Parameterised up-counter with synchronous clear, enable and
//               programmable rollover. On an enabled count at rollover_val
//               the count loads 1 rather than passing through 0.
// Ports       : clk, n_rst (async active-low), clear, count_enable,
//               rollover_val[SIZE-1:0] -> count_out[SIZE-1:0], rollover_flag
//               (registered, high while count_out == rollover_val)
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter
  import rx_bit_timer_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            count_enable,
  input  logic [SIZE-1:0] rollover_val,
  output logic [SIZE-1:0] count_out,
  output logic            rollover_flag
);

  logic [SIZE-1:0] count_q, count_d;
  logic            flag_q, flag_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) count_d = SIZE'(1);
      else                         count_d = count_q + SIZE'(1);
    end
    // Flag tracks the next count so it stays aligned with count_out.
    flag_d = !clear && (count_d == rollover_val);
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : rx_bit_timer
// Description : Receive bit-timing controller. Runs a bit-period counter that
//               re-synchronises on every data edge, raises one sample strobe
//               per bit, counts samples per byte and flags completed bytes.
// Ports       : clk, n_rst (async active-low), enable_timer, d_edge,
//               [bit_stuffed when RX_BIT_TIMER_DESTUFF_EN is defined]
//               -> shift_enable, bit_cnt, byte_received, timer_active
// Config      : RX_BIT_TIMER_DESTUFF_EN - adds bit_stuffed input, which
//               suppresses the sample strobe (and bit count) at stuffed bits.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_bit_timer
  import rx_bit_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE  = DEF_SAMPLE_PHASE,
  parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               enable_timer,
  input  logic                               d_edge,
`ifdef RX_BIT_TIMER_DESTUFF_EN
  input  logic                               bit_stuffed,
`endif
  output logic                               shift_enable,
  output logic [$clog2(BITS_PER_BYTE+1)-1:0] bit_cnt,
  output logic                               byte_received,
  output logic                               timer_active
);

  localparam int PW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(BITS_PER_BYTE + 1);

  localparam logic [PW-1:0] PERIOD_ONE    = PW'(1);
  localparam logic [PW-1:0] PERIOD_MAX    = PW'(CLKS_PER_BIT);
  localparam logic [PW-1:0] PERIOD_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [BW-1:0] BYTE_BITS     = BW'(BITS_PER_BYTE);

  timer_state_t  state_q, state_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic          rollover_seen_q, rollover_seen_d;
  logic          rollover_flag;
  logic          sample_point;
  logic          counter_clear;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      period_cnt_q    <= '0;
      rollover_seen_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      period_cnt_q    <= period_cnt_d;
      rollover_seen_q <= rollover_seen_d;
    end
  end

  // Next state: dropping enable_timer wins over any edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable_timer) state_d = ARM;
      ARM: begin
        if (!enable_timer) state_d = IDLE;
        else if (d_edge)   state_d = RUN;
      end
      RUN:     if (!enable_timer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Period counter: entry into RUN, any data edge and the end of a period
  // all load 1, so an edge coinciding with a wrap needs no special case.
  always_comb begin
    period_cnt_d = '0;
    if (state_d == RUN) begin
      if ((state_q != RUN) || d_edge || (period_cnt_q == PERIOD_MAX))
        period_cnt_d = PERIOD_ONE;
      else
        period_cnt_d = period_cnt_q + PERIOD_ONE;
    end
  end

  assign sample_point = (state_q == RUN) && (period_cnt_q == PERIOD_SAMPLE);

`ifdef RX_BIT_TIMER_DESTUFF_EN
  assign shift_enable = sample_point && !bit_stuffed;
`else
  assign shift_enable = sample_point;
`endif

  // Clear from the next state so that losing enable_timer on the final
  // sample discards the byte instead of completing it.
  assign counter_clear = (state_d != RUN);

  flex_counter #(
    .SIZE (BW)
  ) u_bit_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (counter_clear),
    .count_enable  (shift_enable),
    .rollover_val  (BYTE_BITS),
    .count_out     (bit_cnt),
    .rollover_flag (rollover_flag)
  );

  // Rising edge of the registered rollover flag: high for the single cycle
  // in which bit_cnt first shows a full byte.
  assign rollover_seen_d = rollover_flag;
  assign byte_received   = rollover_flag && !rollover_seen_q;

  assign timer_active = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_bit_timer
// Description : Directed self-checking bench for rx_bit_timer (defaults:
//               8 clocks per bit, sample at period count 3, 8 bits per byte).
//               Cycle 0 of each scenario is the ARM cycle carrying d_edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_bit_timer;

  logic       clk;
  logic       n_rst;
  logic       enable_timer;
  logic       d_edge;
`ifdef RX_BIT_TIMER_DESTUFF_EN
  logic       bit_stuffed;
`endif
  logic       shift_enable;
  logic [3:0] bit_cnt;
  logic       byte_received;
  logic       timer_active;

  int checks = 0;
  int errors = 0;

  rx_bit_timer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .enable_timer  (enable_timer),
    .d_edge        (d_edge),
`ifdef RX_BIT_TIMER_DESTUFF_EN
    .bit_stuffed   (bit_stuffed),
`endif
    .shift_enable  (shift_enable),
    .bit_cnt       (bit_cnt),
    .byte_received (byte_received),
    .timer_active  (timer_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then arm; returns at the start of cycle 0 with state ARM.
  task automatic start_run();
    n_rst = 1'b0; enable_timer = 1'b0; d_edge = 1'b0;
`ifdef RX_BIT_TIMER_DESTUFF_EN
    bit_stuffed = 1'b0;
`endif
    tick(); tick();
    n_rst = 1'b1; enable_timer = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1'b0; enable_timer = 1'b0; d_edge = 1'b0;
`ifdef RX_BIT_TIMER_DESTUFF_EN
    bit_stuffed = 1'b0;
`endif
    #3;
    checks++; if (shift_enable !== 1'b0) begin errors++; $display("FAIL reset shift_enable got %b exp 0", shift_enable); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset bit_cnt got %0d exp 0", bit_cnt); end
    checks++; if (byte_received !== 1'b0) begin errors++; $display("FAIL reset byte_received got %b exp 0", byte_received); end
    checks++; if (timer_active !== 1'b0) begin errors++; $display("FAIL reset timer_active got %b exp 0", timer_active); end
    tick(); n_rst = 1'b1;
    tick(); tick();
    checks++; if (timer_active !== 1'b0) begin errors++; $display("FAIL reset_idle timer_active got %b exp 0", timer_active); end
  endtask

  task automatic test_first_byte();
    logic       exp_shift, exp_byte, exp_act;
    logic [3:0] exp_cnt;
    start_run();
    for (int c = 0; c <= 60; c++) begin
      d_edge = (c == 0);
      #1;
      exp_shift = (c >= 3) && ((c - 3) % 8 == 0);
      exp_cnt   = (c <= 3) ? 4'd0 : 4'((c - 4) / 8 + 1);
      exp_byte  = (c == 60);
      exp_act   = (c >= 1);
      checks++; if (shift_enable !== exp_shift) begin errors++; $display("FAIL first_byte shift_enable c=%0d got %b exp %b", c, shift_enable, exp_shift); end
      checks++; if (bit_cnt !== exp_cnt) begin errors++; $display("FAIL first_byte bit_cnt c=%0d got %0d exp %0d", c, bit_cnt, exp_cnt); end
      checks++; if (byte_received !== exp_byte) begin errors++; $display("FAIL first_byte byte_received c=%0d got %b exp %b", c, byte_received, exp_byte); end
      checks++; if (timer_active !== exp_act) begin errors++; $display("FAIL first_byte timer_active c=%0d got %b exp %b", c, timer_active, exp_act); end
      tick();
    end
  endtask

  // Continues directly after test_first_byte (cycle 61 onward, no edges).
  task automatic test_wrap();
    logic       exp_shift;
    logic [3:0] exp_cnt;
    for (int c = 61; c <= 68; c++) begin
      d_edge = 1'b0;
      #1;
      exp_shift = (c == 67);
      exp_cnt   = (c == 68) ? 4'd1 : 4'd8;
      checks++; if (shift_enable !== exp_shift) begin errors++; $display("FAIL wrap shift_enable c=%0d got %b exp %b", c, shift_enable, exp_shift); end
      checks++; if (bit_cnt !== exp_cnt) begin errors++; $display("FAIL wrap bit_cnt c=%0d got %0d exp %0d", c, bit_cnt, exp_cnt); end
      checks++; if (byte_received !== 1'b0) begin errors++; $display("FAIL wrap byte_received c=%0d got %b exp 0", c, byte_received); end
      tick();
    end
  endtask

  // Edge at cycle 14 (period_cnt 6): strobe moves from 19 to 17, then 25.
  task automatic test_resync();
    logic exp_shift;
    start_run();
    for (int c = 0; c <= 26; c++) begin
      d_edge = (c == 0) || (c == 14);
      #1;
      exp_shift = (c == 3) || (c == 11) || (c == 17) || (c == 25);
      checks++; if (shift_enable !== exp_shift) begin errors++; $display("FAIL resync shift_enable c=%0d got %b exp %b", c, shift_enable, exp_shift); end
      if (c == 14) begin
        checks++; if (dut.period_cnt_q !== 4'd6) begin errors++; $display("FAIL resync period_before got %0d exp 6", dut.period_cnt_q); end
      end
      if (c == 15) begin
        checks++; if (dut.period_cnt_q !== 4'd1) begin errors++; $display("FAIL resync period_after got %0d exp 1", dut.period_cnt_q); end
      end
      if (c == 26) begin
        checks++; if (bit_cnt !== 4'd4) begin errors++; $display("FAIL resync bit_cnt got %0d exp 4", bit_cnt); end
      end
      tick();
    end
  endtask

  // Edge on the sample cycle 11: strobe still fires, next one at 14.
  task automatic test_edge_at_sample();
    logic exp_shift;
    start_run();
    for (int c = 0; c <= 16; c++) begin
      d_edge = (c == 0) || (c == 11);
      #1;
      exp_shift = (c == 3) || (c == 11) || (c == 14);
      checks++; if (shift_enable !== exp_shift) begin errors++; $display("FAIL edge_at_sample shift_enable c=%0d got %b exp %b", c, shift_enable, exp_shift); end
      if (c == 12) begin
        checks++; if (dut.period_cnt_q !== 4'd1) begin errors++; $display("FAIL edge_at_sample period got %0d exp 1", dut.period_cnt_q); end
      end
      tick();
    end
  endtask

  // enable_timer drops with the 8th strobe (cycle 59); re-arm needs an edge.
  task automatic test_enable_drop();
    logic       exp_shift, exp_act;
    logic [3:0] exp_cnt;
    start_run();
    for (int c = 0; c <= 61; c++) begin
      d_edge       = (c == 0);
      enable_timer = (c < 59);
      #1;
      exp_shift = (c >= 3) && (c <= 59) && ((c - 3) % 8 == 0);
      exp_cnt   = (c <= 3 || c >= 60) ? 4'd0 : 4'((c - 4) / 8 + 1);
      exp_act   = (c >= 1) && (c <= 59);
      checks++; if (shift_enable !== exp_shift) begin errors++; $display("FAIL enable_drop shift_enable c=%0d got %b exp %b", c, shift_enable, exp_shift); end
      checks++; if (bit_cnt !== exp_cnt) begin errors++; $display("FAIL enable_drop bit_cnt c=%0d got %0d exp %0d", c, bit_cnt, exp_cnt); end
      checks++; if (byte_received !== 1'b0) begin errors++; $display("FAIL enable_drop byte_received c=%0d got %b exp 0", c, byte_received); end
      checks++; if (timer_active !== exp_act) begin errors++; $display("FAIL enable_drop timer_active c=%0d got %b exp %b", c, timer_active, exp_act); end
      tick();
    end
    for (int c = 62; c <= 85; c++) begin
      enable_timer = 1'b1;
      d_edge       = (c == 81);
      #1;
      exp_shift = (c == 84);
      exp_act   = (c >= 82);
      checks++; if (shift_enable !== exp_shift) begin errors++; $display("FAIL rearm shift_enable c=%0d got %b exp %b", c, shift_enable, exp_shift); end
      checks++; if (timer_active !== exp_act) begin errors++; $display("FAIL rearm timer_active c=%0d got %b exp %b", c, timer_active, exp_act); end
      tick();
    end
  endtask

  // Asynchronous reset in the middle of a byte (bit_cnt 5).
  task automatic test_reset_mid();
    start_run();
    for (int c = 0; c <= 37; c++) begin
      d_edge = (c == 0);
      tick();
    end
    #1;
    checks++; if (bit_cnt !== 4'd5) begin errors++; $display("FAIL reset_mid pre bit_cnt got %0d exp 5", bit_cnt); end
    checks++; if (timer_active !== 1'b1) begin errors++; $display("FAIL reset_mid pre timer_active got %b exp 1", timer_active); end
    n_rst = 1'b0;
    #1;
    checks++; if (shift_enable !== 1'b0) begin errors++; $display("FAIL reset_mid shift_enable got %b exp 0", shift_enable); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_mid bit_cnt got %0d exp 0", bit_cnt); end
    checks++; if (byte_received !== 1'b0) begin errors++; $display("FAIL reset_mid byte_received got %b exp 0", byte_received); end
    checks++; if (timer_active !== 1'b0) begin errors++; $display("FAIL reset_mid timer_active got %b exp 0", timer_active); end
    tick();
    n_rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++; if (shift_enable !== 1'b0 || timer_active !== 1'b0) begin errors++; $display("FAIL reset_mid_idle c=%0d got shift %b active %b exp 0 0", c, shift_enable, timer_active); end
      tick();
    end
  endtask

`ifdef RX_BIT_TIMER_DESTUFF_EN
  // Stuffed bit at the 2nd sample (cycle 11): byte completes one period late.
  task automatic test_destuff();
    logic       exp_shift, exp_byte;
    logic [3:0] exp_cnt;
    exp_cnt = 4'd0;
    start_run();
    for (int c = 0; c <= 68; c++) begin
      d_edge      = (c == 0);
      bit_stuffed = (c == 11);
      #1;
      exp_shift = (c >= 3) && ((c - 3) % 8 == 0) && (c != 11);
      exp_byte  = (c == 68);
      checks++; if (shift_enable !== exp_shift) begin errors++; $display("FAIL destuff shift_enable c=%0d got %b exp %b", c, shift_enable, exp_shift); end
      checks++; if (bit_cnt !== exp_cnt) begin errors++; $display("FAIL destuff bit_cnt c=%0d got %0d exp %0d", c, bit_cnt, exp_cnt); end
      checks++; if (byte_received !== exp_byte) begin errors++; $display("FAIL destuff byte_received c=%0d got %b exp %b", c, byte_received, exp_byte); end
      if (exp_shift) exp_cnt = exp_cnt + 4'd1;
      tick();
    end
    bit_stuffed = 1'b0;
  endtask
`endif

  initial begin
    n_rst = 1'b0; enable_timer = 1'b0; d_edge = 1'b0;
`ifdef RX_BIT_TIMER_DESTUFF_EN
    bit_stuffed = 1'b0;
`endif
    test_reset();
    test_first_byte();
    test_wrap();
    test_resync();
    test_edge_at_sample();
    test_enable_drop();
    test_reset_mid();
`ifdef RX_BIT_TIMER_DESTUFF_EN
    test_destuff();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
